// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter
// Arbitrates the single-port tap coefficient BRAM between the configuration
// requester (cfg) and the FIR compute engine (eng). It range-checks cfg
// accesses, optionally protects the taps while the FIR runs, and steers the
// one-cycle-late RAM read data back to whichever requester issued the read.
//
// Build option: define FIR_TAP_PROTECT_EN for the protected build. In that build,
// while ap_idle is low, cfg reads return all-ones and cfg writes are dropped
// without touching the RAM. Otherwise the shared build applies: the engine has
// priority, and a starvation counter forces a cfg grant after pSTARVE waits.
//
// Ports:
//   axis_clk, axis_rst_n     clock, asynchronous active-low reset
//   ap_idle                  FIR engine idle (not running)
//   cfg_req/we/addr/wdata    configuration request (held until cfg_gnt)
//   cfg_gnt                  combinational accept, access completes this cycle
//   cfg_rvalid/rdata         read response, one cycle after the grant
//   eng_req/addr             engine tap read request (held until eng_gnt)
//   eng_gnt                  combinational accept
//   eng_rvalid/rdata         read response, one cycle after the grant
//   tap_WE/EN/Di/A           BRAM control, address and write data
//   tap_Do                   BRAM read data, registered inside the RAM
module fir_tap_arbiter #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_NUM    = 32,
  parameter int unsigned pSTARVE     = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_idle,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [pADDR_WIDTH-1:0] cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic                   cfg_gnt,
  output logic                   cfg_rvalid,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  typedef enum logic [1:0] {OwnNone, OwnCfg, OwnEng} owner_e;
  typedef enum logic [1:0] {FrcNone, FrcOnes, FrcZero} force_e;

  localparam int unsigned AddrW1 = pADDR_WIDTH + 1;
  localparam logic [pADDR_WIDTH:0] TapLimit = AddrW1'(4 * pTAP_NUM);
  localparam logic [pADDR_WIDTH-1:0] AddrMask = ~(pADDR_WIDTH'(3));

  owner_e rd_owner_q, rd_owner_d;
  force_e rd_force_q, rd_force_d;

  logic cfg_in_range;
  logic cfg_busy;      // cfg access must be answered without touching the RAM
  logic cfg_gnt_w;
  logic eng_gnt_w;
  logic ram_cfg;
  logic ram_eng;

  assign cfg_in_range = ({1'b0, cfg_addr} < TapLimit);

`ifdef FIR_TAP_PROTECT_EN
  // Engine owns the RAM while running; cfg is answered locally, so both can be
  // granted together. When idle, cfg takes the RAM and the engine waits.
  localparam int unsigned UnusedStarve = pSTARVE;

  always_comb begin
    cfg_busy  = !ap_idle;
    cfg_gnt_w = axis_rst_n && cfg_req;
    eng_gnt_w = axis_rst_n && eng_req && !(ap_idle && cfg_req);
  end
`else
  // Engine priority with a starvation escape for cfg.
  localparam int unsigned StW = (pSTARVE < 2) ? 1 : $clog2(pSTARVE + 1);

  logic [StW-1:0] starve_q, starve_d;
  logic           starve_hit;
  logic           unused_idle;

  assign unused_idle = ap_idle;

  always_comb begin
    cfg_busy   = 1'b0;
    starve_hit = cfg_req && (starve_q == StW'(pSTARVE));
    cfg_gnt_w  = axis_rst_n && cfg_req && (!eng_req || starve_hit);
    eng_gnt_w  = axis_rst_n && eng_req && !starve_hit;
    starve_d   = (cfg_req && !cfg_gnt_w) ? starve_q + StW'(1) : '0;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // RAM port drive and response bookkeeping. cfg and eng RAM accesses are
  // mutually exclusive by construction of the grants above.
  always_comb begin
    ram_cfg    = cfg_gnt_w && cfg_in_range && !cfg_busy;
    ram_eng    = eng_gnt_w;
    tap_EN     = ram_cfg || ram_eng;
    tap_WE     = 4'h0;
    tap_Di     = '0;
    tap_A      = '0;
    rd_owner_d = OwnNone;
    rd_force_d = FrcNone;

    if (ram_cfg) begin
      tap_A = cfg_addr & AddrMask;
      if (cfg_we) begin
        tap_WE = 4'hF;
        tap_Di = cfg_wdata;
      end else begin
        rd_owner_d = OwnCfg;
      end
    end else if (ram_eng) begin
      tap_A      = eng_addr & AddrMask;
      rd_owner_d = OwnEng;
    end

    // A cfg read answered without the RAM returns a constant next cycle.
    if (cfg_gnt_w && !cfg_we && !ram_cfg) begin
      rd_force_d = cfg_busy ? FrcOnes : FrcZero;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_owner_q <= OwnNone;
      rd_force_q <= FrcNone;
    end else begin
      rd_owner_q <= rd_owner_d;
      rd_force_q <= rd_force_d;
    end
  end

  always_comb begin
    cfg_gnt    = cfg_gnt_w;
    eng_gnt    = eng_gnt_w;
    cfg_rvalid = (rd_owner_q == OwnCfg) || (rd_force_q != FrcNone);
    eng_rvalid = (rd_owner_q == OwnEng);
    eng_rdata  = eng_rvalid ? tap_Do : '0;
    unique case (rd_force_q)
      FrcOnes: cfg_rdata = '1;
      FrcZero: cfg_rdata = '0;
      default: cfg_rdata = (rd_owner_q == OwnCfg) ? tap_Do : '0;
    endcase
  end

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Self-checking bench for fir_tap_arbiter: a directed vector table, directed
// multi-cycle sequences, and randomized requesters checked against a
// cycle-level reference model of the arbitration rules.
module tb_fir_tap_arbiter;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int NTAP   = 32;
  localparam int STARVE = 8;
`ifdef FIR_TAP_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_idle, cfg_req, cfg_we, eng_req;
  logic [AW-1:0] cfg_addr, eng_addr, tap_A;
  logic [DW-1:0] cfg_wdata, cfg_rdata, eng_rdata, tap_Di, tap_Do;
  logic          cfg_gnt, cfg_rvalid, eng_gnt, eng_rvalid, tap_EN;
  logic [3:0]    tap_WE;

  always #5 clk = ~clk;

  fir_tap_arbiter #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAP_NUM(NTAP), .pSTARVE(STARVE)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .ap_idle(ap_idle),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  // Single-port BRAM with registered read.
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) ram[tap_A[11:2]] <= tap_Di;
      else                tap_Do <= ram[tap_A[11:2]];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_taps [NTAP];
  int          wait_cnt;
  bit          cur_crv, nxt_crv, cur_erv, nxt_erv;
  logic [31:0] cur_crd, nxt_crd, cur_erd, nxt_erd;
  bit          m_cgnt, m_egnt;

  // One clock cycle: drive after the falling edge, check, then advance the model.
  task automatic cyc(input bit idle, input bit creq, input bit cwe, input logic [11:0] caddr,
                     input logic [31:0] cwd, input bit ereq, input logic [11:0] eaddr);
    bit inr, busy, hit, cg, eg, cram;
    int idx;
    @(negedge clk);
    ap_idle = idle; cfg_req = creq; cfg_we = cwe; cfg_addr = caddr; cfg_wdata = cwd;
    eng_req = ereq; eng_addr = eaddr;
    cur_crv = nxt_crv; cur_crd = nxt_crd; cur_erv = nxt_erv; cur_erd = nxt_erd;
    #1;
    inr  = (int'(caddr) < 4 * NTAP);
    busy = Prot && !idle;
    hit  = !Prot && creq && (wait_cnt >= STARVE);
    if (Prot) begin
      cg = creq;
      eg = ereq && !(idle && creq);
    end else begin
      cg = creq && (!ereq || hit);
      eg = ereq && !hit;
    end
    cram = cg && inr && !busy;
    check("cfg_gnt", cfg_gnt, cg);
    check("eng_gnt", eng_gnt, eg);
    check("tap_EN", tap_EN, cram || eg);
    check("tap_A", tap_A, cram ? (caddr & ~12'd3) : eg ? (eaddr & ~12'd3) : 12'd0);
    check("tap_WE", tap_WE, (cram && cwe) ? 4'hF : 4'h0);
    check("tap_Di", tap_Di, (cram && cwe) ? cwd : 32'd0);
    check("cfg_rvalid", cfg_rvalid, cur_crv);
    check("cfg_rdata", cfg_rdata, cur_crd);
    check("eng_rvalid", eng_rvalid, cur_erv);
    check("eng_rdata", eng_rdata, cur_erd);
    idx = int'(caddr >> 2);
    nxt_crv = cg && !cwe;
    nxt_crd = !nxt_crv ? 32'd0 : busy ? 32'hFFFF_FFFF : !inr ? 32'd0 : ref_taps[idx];
    nxt_erv = eg;
    nxt_erd = eg ? ref_taps[int'(eaddr >> 2)] : 32'd0;
    if (cram && cwe) ref_taps[idx] = cwd;
    wait_cnt = (creq && !cg) ? wait_cnt + 1 : 0;
    m_cgnt = cg;
    m_egnt = eg;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_gnt"}, cfg_gnt, 0);
    check({tag, "_eng_gnt"}, eng_gnt, 0);
    check({tag, "_cfg_rvalid"}, cfg_rvalid, 0);
    check({tag, "_eng_rvalid"}, eng_rvalid, 0);
    check({tag, "_cfg_rdata"}, cfg_rdata, 0);
    check({tag, "_eng_rdata"}, eng_rdata, 0);
    check({tag, "_tap_EN"}, tap_EN, 0);
    check({tag, "_tap_WE"}, tap_WE, 0);
    check({tag, "_tap_A"}, tap_A, 0);
    check({tag, "_tap_Di"}, tap_Di, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          idle, creq, cwe;
    logic [11:0] caddr;
    logic [31:0] cwd;
    bit          ereq;
    logic [11:0] eaddr;
    bit          x_cg, x_eg, x_en;
    logic [11:0] x_a;
    logic [3:0]  x_we;
    bit          x_crv;
    logic [31:0] x_crd;
    bit          x_erv;
    logic [31:0] x_erd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit          cpend, epend, idle_h, cwe_h;
    logic [11:0] caddr_h, eaddr_h;
    logic [31:0] cwd_h, old_val;
    int          gnt_cycle;
    logic        eng_at_gnt;

    // Tap 1 lives at byte offset 0x04; 0x80 is the first offset past 32 taps.
    //            idle creq we  caddr     wdata  ereq eaddr    cg eg en a        we    crv crd    erv erd
    tbl[0] = '{1, 1, 1, 12'h004, 32'hB, 0, 12'h000, 1, 0, 1, 12'h004, 4'hF, 0, 32'h0, 0, 32'h0};
    tbl[1] = '{1, 1, 0, 12'h004, 32'h0, 0, 12'h000, 1, 0, 1, 12'h004, 4'h0, 0, 32'h0, 0, 32'h0};
    tbl[2] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 12'h000, 4'h0, 1, 32'hB, 0, 32'h0};
    tbl[3] = '{1, 1, 0, 12'h080, 32'h0, 0, 12'h000, 1, 0, 0, 12'h000, 4'h0, 0, 32'h0, 0, 32'h0};
    tbl[4] = '{1, 1, 1, 12'h080, 32'h7, 0, 12'h000, 1, 0, 0, 12'h000, 4'h0, 1, 32'h0, 0, 32'h0};
    tbl[5] = '{1, 0, 0, 12'h000, 32'h0, 1, 12'h004, 0, 1, 1, 12'h004, 4'h0, 0, 32'h0, 0, 32'h0};
    tbl[6] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 12'h000, 4'h0, 0, 32'h0, 1, 32'hB};
    tbl[7] = '{1, 1, 0, 12'h006, 32'h0, 0, 12'h000, 1, 0, 1, 12'h004, 4'h0, 0, 32'h0, 0, 32'h0};
    tbl[8] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 12'h000, 4'h0, 1, 32'hB, 0, 32'h0};

    rst_n = 1'b0;
    ap_idle = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    eng_req = 1'b0; eng_addr = '0;
    nxt_crv = 0; nxt_erv = 0; nxt_crd = 0; nxt_erd = 0; wait_cnt = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ap_idle = tbl[i].idle; cfg_req = tbl[i].creq; cfg_we = tbl[i].cwe;
      cfg_addr = tbl[i].caddr; cfg_wdata = tbl[i].cwd;
      eng_req = tbl[i].ereq; eng_addr = tbl[i].eaddr;
      #1;
      check($sformatf("tbl%0d_cfg_gnt", i), cfg_gnt, tbl[i].x_cg);
      check($sformatf("tbl%0d_eng_gnt", i), eng_gnt, tbl[i].x_eg);
      check($sformatf("tbl%0d_tap_EN", i), tap_EN, tbl[i].x_en);
      check($sformatf("tbl%0d_tap_A", i), tap_A, tbl[i].x_a);
      check($sformatf("tbl%0d_tap_WE", i), tap_WE, tbl[i].x_we);
      check($sformatf("tbl%0d_cfg_rvalid", i), cfg_rvalid, tbl[i].x_crv);
      check($sformatf("tbl%0d_cfg_rdata", i), cfg_rdata, tbl[i].x_crd);
      check($sformatf("tbl%0d_eng_rvalid", i), eng_rvalid, tbl[i].x_erv);
      check($sformatf("tbl%0d_eng_rdata", i), eng_rdata, tbl[i].x_erd);
    end

    // Preload all taps through the cfg port while idle.
    for (int i = 0; i < NTAP; i++) cyc(1, 1, 1, 12'(i * 4), $urandom, 0, 12'h0);

    // Engine streams one read per cycle while running.
    for (int i = 0; i < NTAP; i++) begin
      cyc(0, 0, 0, 12'h0, 32'h0, 1, 12'(i * 4));
      if (i > 0) check("stream_eng_rvalid", eng_rvalid, 1);
    end
    cyc(0, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    check("stream_last_rvalid", eng_rvalid, 1);

`ifndef FIR_TAP_PROTECT_EN
    // cfg held against a streaming engine: forced grant on the 9th waiting cycle.
    gnt_cycle = 0; eng_at_gnt = 1'b1; eaddr_h = 12'h0;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 1, 0, 12'h010, 32'h0, 1, eaddr_h);
      if (cfg_gnt === 1'b1 && gnt_cycle == 0) begin
        gnt_cycle = k;
        eng_at_gnt = eng_gnt;
      end
      if (m_egnt) eaddr_h = (eaddr_h + 12'h4) & 12'h07C;
      if (m_cgnt) break;
    end
    check("starve_gnt_cycle", gnt_cycle, 9);
    check("starve_eng_gnt", eng_at_gnt, 0);
    cyc(0, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    check("starve_cfg_rdata", cfg_rdata, ref_taps[4]);
`else
    // Running: read answered locally with all-ones, write dropped.
    old_val = ref_taps[1];
    cyc(0, 1, 0, 12'h004, 32'h0, 0, 12'h0);
    check("busy_rd_gnt", cfg_gnt, 1);
    check("busy_rd_en", tap_EN, 0);
    cyc(0, 1, 1, 12'h004, 32'h5, 0, 12'h0);
    check("busy_wr_en", tap_EN, 0);
    check("busy_rd_data", cfg_rdata, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 12'h004, 32'h0, 0, 12'h0);
    check("idle_rd_en", tap_EN, 1);
    cyc(1, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    check("idle_rd_old", cfg_rdata, old_val);
    // Simultaneous idle requests: cfg first, engine next.
    cyc(1, 1, 0, 12'h008, 32'h0, 1, 12'h00C);
    check("sim_cfg_gnt", cfg_gnt, 1);
    check("sim_eng_wait", eng_gnt, 0);
    cyc(1, 0, 0, 12'h0, 32'h0, 1, 12'h00C);
    check("sim_eng_gnt", eng_gnt, 1);
    check("sim_cfg_rv", cfg_rvalid, 1);
    check("sim_no_eng_rv", eng_rvalid, 0);
    cyc(1, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    check("sim_eng_rv", eng_rvalid, 1);
    check("sim_no_cfg_rv", cfg_rvalid, 0);
    check("sim_eng_rdata", eng_rdata, ref_taps[3]);
`endif

    // Randomized requesters obeying the hold-until-grant handshake.
    cpend = 0; epend = 0; idle_h = 1; cwe_h = 0;
    caddr_h = '0; eaddr_h = '0; cwd_h = '0;
    for (int n = 0; n < 800; n++) begin
      if (!cpend && $urandom_range(0, 2) == 0) begin
        cpend   = 1;
        cwe_h   = 1'($urandom_range(0, 1));
        caddr_h = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(128, 255))
                                              : 12'($urandom_range(0, 127));
        cwd_h   = $urandom;
      end
      if (!epend && $urandom_range(0, 1) == 1) begin
        epend   = 1;
        eaddr_h = 12'($urandom_range(0, NTAP - 1) * 4);
      end
      if ($urandom_range(0, 15) == 0) idle_h = !idle_h;
      cyc(idle_h, cpend, cwe_h, caddr_h, cwd_h, epend, eaddr_h);
      if (m_cgnt) cpend = 0;
      if (m_egnt) epend = 0;
    end
    cyc(1, 0, 0, 12'h0, 32'h0, 0, 12'h0);

    // Reset while a read is granted: no response, outputs cleared at once.
    cyc(1, 1, 0, 12'h008, 32'h0, 0, 12'h0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk);
    #1 check("rst_no_rvalid", cfg_rvalid, 0);
    @(negedge clk);
    cfg_req = 1'b0; eng_req = 1'b0;
    rst_n = 1'b1;
    nxt_crv = 0; nxt_erv = 0; nxt_crd = 0; nxt_erd = 0; wait_cnt = 0;
    cyc(1, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    cyc(1, 1, 0, 12'h008, 32'h0, 0, 12'h0);
    cyc(1, 0, 0, 12'h0, 32'h0, 0, 12'h0);
    check("post_rst_rdata", cfg_rdata, ref_taps[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
